cm_sort_ser: RTL and testbench

Serializer for the parallel output of the team's vector sorter. Captures one DCNT-lane vector (lane 0 first, ascending after sorting) under a valid/ready handshake and emits its elements one per beat, tagged with lane index and a last flag. Optional duplicate suppression drops repeated values. Sits directly downstream of the sorter, feeding narrow streaming consumers.

---
 rtl/cm_sort_ser_if.sv | 27 ++
 rtl/cm_sort_ser.sv | 84 ++++++++
 tb/tb_cm_sort_ser.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cm_sort_ser_if.sv
// Handshake bundle for cm_sort_ser: vector capture side (i_vld/o_rdy/i_data)
// and beat emission side (o_vld/i_rdy/o_data/o_idx/o_last).
interface cm_sort_ser_if #(
  parameter int DCNT   = 8,
  parameter int DWIDTH = 8
);
  localparam int IW = $clog2(DCNT);

  logic                         i_vld;
  logic                         o_rdy;
  logic [DCNT-1:0][DWIDTH-1:0]  i_data;
  logic                         o_vld;
  logic                         i_rdy;
  logic [DWIDTH-1:0]            o_data;
  logic [IW-1:0]                o_idx;
  logic                         o_last;

  modport master (
    output i_vld, i_data, i_rdy,
    input  o_rdy, o_vld, o_data, o_idx, o_last
  );

  modport slave (
    input  i_vld, i_data, i_rdy,
    output o_rdy, o_vld, o_data, o_idx, o_last
  );
endinterface

// File: rtl/cm_sort_ser.sv
// Serializes one captured DCNT-lane vector into single-element beats tagged
// with lane index and last flag; optional suppression of repeated values.
module cm_sort_ser #(
  parameter int DCNT     = 8,
  parameter int DWIDTH   = 8,
  parameter int SKIP_DUP = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  cm_sort_ser_if.slave  bus
);
  localparam int IW = $clog2(DCNT);
  typedef logic [DCNT-1:0][DWIDTH-1:0] vec_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]        state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [DWIDTH-1:0] data_q;
  logic              last_q;
  logic              last_d;
  logic              first_last;
  vec_t              vec_q;
  logic              acc;
  logic              fire;

  // A lane above p is a successor if it differs from lane p (or always, without dup suppression).
  function automatic logic has_next(input vec_t v, input logic [IW-1:0] p);
    has_next = 1'b0;
    for (int j = 0; j < DCNT; j++) begin
      if (j > int'(p) && (SKIP_DUP == 0 || v[j] != v[p])) has_next = 1'b1;
    end
  endfunction

  function automatic logic [IW-1:0] next_lane(input vec_t v, input logic [IW-1:0] p);
    next_lane = p;
    for (int j = DCNT - 1; j >= 0; j--) begin
      if (j > int'(p) && (SKIP_DUP == 0 || v[j] != v[p])) next_lane = IW'(j);
    end
  endfunction

  assign fire        = (state_q == ST_DRAIN) && bus.i_rdy;
  assign bus.o_rdy   = !i_rst && ((state_q == ST_IDLE) || (fire && last_q));
  assign acc         = bus.o_rdy && bus.i_vld;
  assign bus.o_vld   = (state_q == ST_DRAIN);
  assign bus.o_data  = data_q;
  assign bus.o_idx   = ptr_q;
  assign bus.o_last  = last_q;

  always_comb begin
    ptr_d      = next_lane(vec_q, ptr_q);
    last_d     = !has_next(vec_q, ptr_d);
    first_last = !has_next(bus.i_data, {IW{1'b0}});
  end

  always_ff @(posedge i_clk) begin
    if (acc) vec_q <= bus.i_data;
  end

  // Capture takes priority: on a last-beat transfer with i_vld the next vector loads directly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (acc) begin
      state_q <= ST_DRAIN;
      ptr_q   <= '0;
      data_q  <= bus.i_data[0];
      last_q  <= first_last;
    end else if (fire) begin
      if (last_q) begin
        state_q <= ST_IDLE;
      end else begin
        ptr_q  <= ptr_d;
        data_q <= vec_q[ptr_d];
        last_q <= last_d;
      end
    end
  end
endmodule

// File: tb/tb_cm_sort_ser.sv
// Bench for cm_sort_ser: two instances (SKIP_DUP 0 and 1) share stimulus and are
// compared each cycle against a beat-list model built from each captured vector.
module tb_cm_sort_ser;
  localparam int DCNT = 8;
  localparam int DW   = 8;
  typedef logic [DCNT-1:0][DW-1:0] vec_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic rdy = 1'b1;
  vec_t data = '0;
  bit   cmp_en = 1'b0;

  int total = 0;
  int bad   = 0;
  int acc0  = 0;
  int acc1  = 0;

  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  cm_sort_ser_if #(.DCNT(DCNT), .DWIDTH(DW)) if0 ();
  cm_sort_ser_if #(.DCNT(DCNT), .DWIDTH(DW)) if1 ();

  assign if0.i_vld = vld;  assign if0.i_data = data;  assign if0.i_rdy = rdy;
  assign if1.i_vld = vld;  assign if1.i_data = data;  assign if1.i_rdy = rdy;

  cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DW), .SKIP_DUP(0)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DW), .SKIP_DUP(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // With suppression, a lane is emitted iff it differs from the lane just below it.
  function automatic int build(input vec_t v, input bit skip, output beat_t arr[DCNT]);
    int n = 0;
    for (int j = 0; j < DCNT; j++) arr[j] = '0;
    for (int j = 0; j < DCNT; j++) begin
      if (!skip || j == 0 || v[j] != v[j-1]) begin
        arr[n].d    = v[j];
        arr[n].idx  = 3'(j);
        arr[n].last = 1'b0;
        n++;
      end
    end
    arr[n-1].last = 1'b1;
    return n;
  endfunction

  function automatic vec_t gen_vec();
    vec_t v;
    if ($urandom_range(3) == 0) begin
      for (int j = 0; j < DCNT; j++) v[j] = DW'($urandom_range(3));
    end else begin
      v[0] = DW'($urandom_range(3));
      for (int j = 1; j < DCNT; j++)
        v[j] = v[j-1] + (($urandom_range(2) == 0) ? DW'($urandom_range(4)) : DW'(0));
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    beat_t arr[DCNT];
    int    n;
    bit    a0, a1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      a0 = vld && (q0.size() == 0 || (rdy && q0.size() == 1));
      a1 = vld && (q1.size() == 0 || (rdy && q1.size() == 1));
      if (q0.size() != 0 && rdy) void'(q0.pop_front());
      if (q1.size() != 0 && rdy) void'(q1.pop_front());
      if (a0) begin
        n = build(data, 1'b0, arr);
        for (int i = 0; i < n; i++) q0.push_back(arr[i]);
        acc0++;
      end
      if (a1) begin
        n = build(data, 1'b1, arr);
        for (int i = 0; i < n; i++) q1.push_back(arr[i]);
        acc1++;
      end
    end
  end

  task automatic cmp_side(input string nm, input logic ov, input logic ordy, input logic [DW-1:0] od,
                          input logic [2:0] oi, input logic ol, input int qsz, input beat_t f);
    check({nm, " o_vld"}, 32'(ov), 32'(qsz != 0));
    check({nm, " o_rdy"}, 32'(ordy), 32'(!rst && (qsz == 0 || (rdy && qsz == 1))));
    if (qsz != 0) begin
      check({nm, " o_data"}, 32'(od), 32'(f.d));
      check({nm, " o_idx"},  32'(oi), 32'(f.idx));
      check({nm, " o_last"}, 32'(ol), 32'(f.last));
    end
  endtask

  always @(negedge clk) begin : compare
    beat_t f;
    if (cmp_en) begin
      f = '0; if (q0.size() != 0) f = q0[0];
      cmp_side("s0", if0.o_vld, if0.o_rdy, if0.o_data, if0.o_idx, if0.o_last, q0.size(), f);
      f = '0; if (q1.size() != 0) f = q1[0];
      cmp_side("s1", if1.o_vld, if1.o_rdy, if1.o_data, if1.o_idx, if1.o_last, q1.size(), f);
    end
  end

  task automatic put_one(input vec_t v);
    @(posedge clk); #1;
    vld = 1'b1; data = v;
    @(posedge clk); #1;
    vld = 1'b0;
    check("lane0 vld s0", 32'(if0.o_vld), 32'd1);
    check("lane0 idx s1", 32'(if1.o_idx), 32'd0);
    check("lane0 data s0", 32'(if0.o_data), 32'(v[0]));
    repeat (12) @(posedge clk);
  endtask

  initial begin
    vec_t  tv, tc;
    beat_t arr[DCNT];
    int    n, gaps;
    logic [7:0] exp_dat [6];
    logic [2:0] exp_idx [6];
    exp_dat = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'hA0};
    exp_idx = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7};
    tv = {8'hA0, 8'h05, 8'h03, 8'h03, 8'h02, 8'h01, 8'h01, 8'h00};
    tc = {DCNT{8'h3C}};

    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst o_vld s0", 32'(if0.o_vld), 32'd0);
    check("rst o_rdy s0", 32'(if0.o_rdy), 32'd0);
    check("rst o_data s0", 32'(if0.o_data), 32'd0);
    check("rst o_idx s0", 32'(if0.o_idx), 32'd0);
    check("rst o_last s0", 32'(if0.o_last), 32'd0);
    check("rst o_vld s1", 32'(if1.o_vld), 32'd0);
    check("rst o_rdy s1", 32'(if1.o_rdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("post-rst o_rdy s0", 32'(if0.o_rdy), 32'd1);

    n = build(tv, 1'b0, arr);
    check("model n nodup", 32'(n), 32'd8);
    check("model last data nodup", 32'(arr[7].d), 32'hA0);
    check("model last flag nodup", 32'(arr[7].last), 32'd1);
    check("model early last nodup", 32'(arr[6].last), 32'd0);
    n = build(tv, 1'b1, arr);
    check("model n dup", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("model dup data", 32'(arr[i].d), 32'(exp_dat[i]));
      check("model dup idx", 32'(arr[i].idx), 32'(exp_idx[i]));
    end
    n = build(tc, 1'b1, arr);
    check("model n const", 32'(n), 32'd1);
    check("model const last", 32'(arr[0].last), 32'd1);

    rdy = 1'b1;
    put_one(tv);
    put_one(tc);

    // Back-to-back: vld held, data changing every cycle.
    @(posedge clk); #1;
    vld = 1'b1;
    gaps = 0;
    for (int c = 0; c < 60; c++) begin
      data = gen_vec();
      @(posedge clk); #1;
      if (!if0.o_vld) gaps++;
    end
    check("b2b gaps s0", 32'(gaps), 32'd0);

    // Random vld/rdy/data until 100 vectors taken by the non-suppressing instance.
    acc0 = 0;
    for (int c = 0; c < 6000 && acc0 < 100; c++) begin
      @(posedge clk); #1;
      vld  = ($urandom_range(3) != 0);
      rdy  = $urandom_range(1);
      data = gen_vec();
    end
    check("random vectors reached", 32'(acc0 >= 100), 32'd1);
    vld = 1'b0; rdy = 1'b1;
    repeat (20) @(posedge clk);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    vld = 1'b1; data = tv;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst o_vld s0", 32'(if0.o_vld), 32'd0);
    check("midrst o_vld s1", 32'(if1.o_vld), 32'd0);
    check("midrst o_idx s0", 32'(if0.o_idx), 32'd0);
    check("midrst o_data s0", 32'(if0.o_data), 32'd0);
    check("midrst o_rdy s0", 32'(if0.o_rdy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("after rst o_rdy s0", 32'(if0.o_rdy), 32'd1);
    check("after rst o_rdy s1", 32'(if1.o_rdy), 32'd1);
    put_one(tv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
